led_scanner: RTL and testbench

//  Parametrised LED chaser, driven from the 50 MHz board clock. It generalises the

---
 rtl/led_scanner.sv | 148 ++++++++++++++
 tb/tb_led_scanner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/led_scanner.sv
// N-LED chaser with its own step prescaler: bounce, rotate up/down or hold,
// with optional trail of the previous position. All outputs come from registers.

module led_cell #(
    parameter int PW  = 4,
    parameter int IDX = 0
) (
    input  logic [PW-1:0] pos,
    input  logic [PW-1:0] prev,
    input  logic          trail,
    output logic          lit
);
    localparam logic [PW-1:0] ID = PW'(IDX);

    assign lit = (pos == ID) | (trail & (prev == ID));
endmodule

module led_scanner #(
    parameter  int N_LEDS   = 10,
    parameter  int DIV_BASE = 25_000_000,
    localparam int PW       = $clog2(N_LEDS)
) (
    input  logic              clock_50,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    input  logic              pause,
    input  logic              trail_en,
    output logic [N_LEDS-1:0] leds,
    output logic [PW-1:0]     pos,
    output logic              dir,
    output logic              step
);
    localparam int CW = $clog2(DIV_BASE + 1);

    localparam logic [CW-1:0] TERM0 = CW'((DIV_BASE >> 0) - 1);
    localparam logic [CW-1:0] TERM1 = CW'((DIV_BASE >> 1) - 1);
    localparam logic [CW-1:0] TERM2 = CW'((DIV_BASE >> 2) - 1);
    localparam logic [CW-1:0] TERM3 = CW'((DIV_BASE >> 3) - 1);

    localparam logic [PW-1:0] ZERO  = '0;
    localparam logic [PW-1:0] ONE   = PW'(1);
    localparam logic [PW-1:0] LAST  = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] PENUL = PW'(N_LEDS - 2);

    typedef enum logic [1:0] {
        M_BOUNCE = 2'b00,
        M_UP     = 2'b01,
        M_DOWN   = 2'b10,
        M_HOLD   = 2'b11
    } mode_e;

    logic [CW-1:0] cnt, cnt_nxt, term;
    logic [PW-1:0] prev, pos_nxt, prev_nxt;
    logic          dir_nxt, step_nxt, trail_q, tick;
    mode_e         mode_sel;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        term = TERM0;
        case (speed)
            2'd0: term = TERM0;
            2'd1: term = TERM1;
            2'd2: term = TERM2;
            2'd3: term = TERM3;
            default: term = TERM0;
        endcase
    end

    // >= rather than == so a speed increase mid-count ticks immediately instead of wrapping
    assign tick = !pause && (cnt >= term);

    always_comb begin
        cnt_nxt  = cnt;
        pos_nxt  = pos;
        prev_nxt = prev;
        dir_nxt  = dir;
        step_nxt = 1'b0;
        if (tick)
            cnt_nxt = '0;
        else if (!pause)
            cnt_nxt = cnt + 1'b1;

        if (tick && mode_sel != M_HOLD) begin
            step_nxt = 1'b1;
            prev_nxt = pos;
            case (mode_sel)
                M_BOUNCE: begin
                    if (!dir) begin
                        if (pos != LAST) begin
                            pos_nxt = pos + 1'b1;
                            dir_nxt = (pos == PENUL);
                        end else begin
                            // entered bounce sitting on the top end while moving up
                            pos_nxt = PENUL;
                            dir_nxt = 1'b1;
                        end
                    end else begin
                        if (pos != ZERO) begin
                            pos_nxt = pos - 1'b1;
                            dir_nxt = (pos != ONE);
                        end else begin
                            pos_nxt = ONE;
                            dir_nxt = 1'b0;
                        end
                    end
                end
                M_UP: begin
                    pos_nxt = (pos == LAST) ? ZERO : pos + 1'b1;
                    dir_nxt = 1'b0;
                end
                M_DOWN: begin
                    pos_nxt = (pos == ZERO) ? LAST : pos - 1'b1;
                    dir_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            cnt     <= '0;
            pos     <= '0;
            prev    <= '0;
            dir     <= 1'b0;
            step    <= 1'b0;
            trail_q <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            pos     <= pos_nxt;
            prev    <= prev_nxt;
            dir     <= dir_nxt;
            step    <= step_nxt;
            trail_q <= trail_en;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_led
        led_cell #(.PW(PW), .IDX(i)) u_cell (
            .pos   (pos),
            .prev  (prev),
            .trail (trail_q),
            .lit   (leds[i])
        );
    end
endmodule

// File: tb/tb_led_scanner.sv
// Scoreboard bench for led_scanner (N_LEDS=10, DIV_BASE=8): every expected step
// carries the edge number it must appear on; a negedge monitor pops and compares.

module tb_led_scanner;
    logic       clock_50 = 1'b0;
    logic       reset_n, pause, trail_en;
    logic [1:0] mode, speed;
    logic [9:0] leds;
    logic [3:0] pos;
    logic       dir, step;

    led_scanner #(.N_LEDS(10), .DIV_BASE(8)) dut (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .mode     (mode),
        .speed    (speed),
        .pause    (pause),
        .trail_en (trail_en),
        .leds     (leds),
        .pos      (pos),
        .dir      (dir),
        .step     (step)
    );

    always #10 clock_50 = ~clock_50;

    typedef struct {
        int       cyc;
        int       pos;
        bit       dir;
        logic [9:0] leds;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clock_50) cyc <= cyc + 1;

    task automatic push(input int at, input int p, input bit d, input logic [9:0] l);
        exp_t e;
        e.cyc = at; e.pos = p; e.dir = d; e.leds = l;
        sb.push_back(e);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clock_50);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // monitor: every step pulse must match the head of the scoreboard, on the right edge
    always @(negedge clock_50) begin
        if (step === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_step: edge %0d pos=%0d, expected no step", cyc, pos);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc || int'(pos) != e.pos || dir !== e.dir || leds !== e.leds) begin
                    n_err++;
                    $display("FAIL step: edge=%0d pos=%0d dir=%0b leds=%h, expected edge=%0d pos=%0d dir=%0b leds=%h",
                             cyc, pos, dir, leds, e.cyc, e.pos, e.dir, e.leds);
                end
            end
        end
    end

    int         bpos [26] = '{2,3,4,5,6,7,8,9,8,7,6,5,4,3,2,1,0,1,2,3,4,5,6,7,8,9};
    bit         bdir [26] = '{0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,1};
    int         tpos [16] = '{5,4,3,2,1,0,1,2,3,4,5,6,7,8,9,8};
    bit         tdir [16] = '{1,1,1,1,1,0,0,0,0,0,0,0,0,0,1,1};
    logic [9:0] tled [16] = '{10'h060,10'h030,10'h018,10'h00C,10'h006,10'h003,10'h003,10'h006,
                              10'h00C,10'h018,10'h030,10'h060,10'h0C0,10'h180,10'h300,10'h300};

    initial begin
        int c;
        reset_n = 1'b0; mode = 2'b00; speed = 2'd0; pause = 1'b0; trail_en = 1'b0;

        // reset state, then first step 8 edges after release
        tick_n(3);
        check("reset_leds", int'(leds), 1);
        check("reset_pos", int'(pos), 0);
        check("reset_dir", int'(dir), 0);
        check("reset_step", int'(step), 0);
        reset_n = 1'b1;
        c = cyc;
        push(c + 8, 1, 1'b0, 10'h002);
        tick_n(8);

        // bounce at one step per cycle, through both ends and up to 9 again
        speed = 2'd3;
        c = cyc;
        for (int i = 0; i < 26; i++) begin
            logic [9:0] oh;
            oh = 10'h001 << bpos[i];
            push(c + 1 + i, bpos[i], bdir[i], oh);
        end
        tick_n(26);

        // rotate up wraps 9->0, rotate down wraps 0->9
        mode = 2'b01;
        c = cyc;
        push(c + 1, 0, 1'b0, 10'h001);
        push(c + 2, 1, 1'b0, 10'h002);
        tick_n(2);
        mode = 2'b10;
        c = cyc;
        push(c + 1, 0, 1'b1, 10'h001);
        push(c + 2, 9, 1'b1, 10'h200);
        tick_n(2);

        // pause at cnt=5 for 50 cycles, then step after 3 more
        speed = 2'd0;
        tick_n(5);
        pause = 1'b1;
        tick_n(50);
        check("pause_pos_held", int'(pos), 9);
        pause = 1'b0;
        c = cyc;
        push(c + 3, 8, 1'b1, 10'h100);
        tick_n(3);

        // speed raised with cnt=6: immediate step, then every cycle
        tick_n(6);
        speed = 2'd3;
        c = cyc;
        push(c + 1, 7, 1'b1, 10'h080);
        push(c + 2, 6, 1'b1, 10'h040);
        tick_n(2);
        mode = 2'b11;
        tick_n(10);
        check("hold_pos", int'(pos), 6);
        check("hold_step", int'(step), 0);

        // trail in bounce, then reset mid-sweep
        mode = 2'b00;
        trail_en = 1'b1;
        c = cyc;
        for (int i = 0; i < 16; i++) push(c + 1 + i, tpos[i], tdir[i], tled[i]);
        tick_n(16);
        reset_n = 1'b0;
        tick_n(1);
        check("midreset_leds", int'(leds), 1);
        check("midreset_pos", int'(pos), 0);
        check("midreset_step", int'(step), 0);
        tick_n(2);
        check("missing_steps", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
